// File: rtl/rgbi_pkg.sv
// Shared definitions for the RGBI palette pipeline.
//   state_t        : table FSM states (INIT fills defaults, RUN serves pixels)
//   lut_depth()    : number of table entries for a given colour/intensity width
//   default_entry(): power-on table contents, colour * intensity scaled to OW bits
package rgbi_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int unsigned lut_depth(input int unsigned cw, input int unsigned iw);
        return 32'd1 << (cw + iw);
    endfunction

    // The product needs cw+iw bits; keep its top ow bits when narrowing,
    // otherwise the value is returned as-is (zero-extended by the caller).
    function automatic logic [31:0] default_entry(input logic [31:0] c,
                                                  input logic [31:0] i,
                                                  input int unsigned cw,
                                                  input int unsigned iw,
                                                  input int unsigned ow);
        logic [31:0] p;
        p = (c * i) & ((32'd1 << (cw + iw)) - 32'd1);
        if (ow <= cw + iw) begin
            return p >> (cw + iw - ow);
        end
        return p;
    endfunction

endpackage

// File: rtl/rgbi_lut_ram.sv
// One replica of the palette table: single write port, single synchronous
// read port. A read and write to the same address in one cycle returns the
// previous contents.
//   clk   : clock
//   we    : write enable, waddr/wdata : write address/data
//   re    : read enable (holds rdata when low), raddr : read address
//   rdata : registered read data
module rgbi_lut_ram #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [1 << AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/rgbi_palette_pipe.sv
// RGBI colour lookup pipeline: NCH colour channels plus a shared intensity
// nibble are mapped through a download-writable table to OW-bit video, with
// blanking/sync delayed to stay aligned. Three ce_pix-qualified stages.
//   clk_video, reset (sync, active-high), ce_pix (pipeline advance)
//   col_in/int_in           : packed colour channels (ch0 in LSBs), intensity
//   hblank/vblank/hs/vs_in  : timing inputs
//   dn_wr/dn_addr/dn_data   : table download port ({colour,intensity} index)
//   busy                    : high while the table is filled with defaults
//   col_out, *_out          : packed video and delayed timing
module rgbi_palette_pipe
    import rgbi_pkg::*;
#(
    parameter int CW          = 4,
    parameter int IW          = 4,
    parameter int OW          = 8,
    parameter int NCH         = 3,
    parameter bit BLANK_BLACK = 1'b1
) (
    input  logic                clk_video,
    input  logic                reset,
    input  logic                ce_pix,
    input  logic [NCH*CW-1:0]   col_in,
    input  logic [IW-1:0]       int_in,
    input  logic                hblank_in,
    input  logic                vblank_in,
    input  logic                hs_in,
    input  logic                vs_in,
    input  logic                dn_wr,
    input  logic [CW+IW-1:0]    dn_addr,
    input  logic [OW-1:0]       dn_data,
    output logic                busy,
    output logic [NCH*OW-1:0]   col_out,
    output logic                hblank_out,
    output logic                vblank_out,
    output logic                hs_out,
    output logic                vs_out
);

    localparam int AW    = CW + IW;
    localparam int DEPTH = lut_depth(CW, IW);

    state_t        state;
    logic [AW-1:0] fill;
    logic          busy_r;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [OW-1:0] wr_data;
    logic [31:0]   def_entry;

    // Timing bundle order: {vs, hs, vblank, hblank}
    logic [NCH*CW-1:0] col_p0;
    logic [IW-1:0]     int_p0;
    logic [3:0]        tim_p0;
    logic              vld_p0;

    logic [OW-1:0]     rd_p1 [NCH];
    logic [IW-1:0]     int_p1;
    logic [3:0]        tim_p1;
    logic              vld_p1;
    logic              busy_p1;
    logic              zero_p1;

    logic [NCH*OW-1:0] col_p2;
    logic [3:0]        tim_p2;

    always_ff @(posedge clk_video) begin
        if (reset) begin
            state  <= INIT;
            fill   <= '0;
            busy_r <= 1'b1;
        end else if (state == INIT) begin
            fill <= fill + 1'b1;
            if (fill == AW'(DEPTH - 1)) begin
                state  <= RUN;
                busy_r <= 1'b0;
            end
        end
    end

    always_comb begin
        def_entry = default_entry(32'(fill[AW-1:IW]), 32'(fill[IW-1:0]), CW, IW, OW);
    end

    // The fill sequence owns the write port in INIT; downloads are dropped.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = dn_addr;
        wr_data = dn_data;
        if (!reset) begin
            if (state == INIT) begin
                wr_en   = 1'b1;
                wr_addr = fill;
                wr_data = def_entry[OW-1:0];
            end else begin
                wr_en = dn_wr;
            end
        end
    end

    // Stage valids: stage contents are meaningless until data has flowed in
    // after reset, and a read issued while the fill is running may be stale.
    always_ff @(posedge clk_video) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            busy_p1 <= 1'b1;
        end else if (ce_pix) begin
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
            busy_p1 <= busy_r;
        end
    end

    // ---- S1: input register ----
    always_ff @(posedge clk_video) begin
        if (ce_pix) begin
            col_p0 <= col_in;
            int_p0 <= int_in;
            tim_p0 <= {vs_in, hs_in, vblank_in, hblank_in};
        end
    end

    // ---- S2: table read, timing carried alongside ----
    always_ff @(posedge clk_video) begin
        if (ce_pix) begin
            int_p1 <= int_p0;
            tim_p1 <= tim_p0;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_lut
        rgbi_lut_ram #(
            .DW(OW),
            .AW(AW)
        ) u_lut (
            .clk   (clk_video),
            .we    (wr_en),
            .waddr (wr_addr),
            .wdata (wr_data),
            .re    (ce_pix),
            .raddr ({col_p0[k*CW +: CW], int_p0}),
            .rdata (rd_p1[k])
        );
    end

    always_comb begin
        zero_p1 = !vld_p1 || busy_r || busy_p1 || (int_p1 == '0) ||
                  (BLANK_BLACK && (tim_p1[0] || tim_p1[1]));
    end

    // ---- S3: output register ----
    always_ff @(posedge clk_video) begin
        if (reset) begin
            col_p2 <= '0;
            tim_p2 <= '0;
        end else if (ce_pix) begin
            tim_p2 <= vld_p1 ? tim_p1 : 4'b0000;
            for (int k = 0; k < NCH; k++) begin
                col_p2[k*OW +: OW] <= zero_p1 ? '0 : rd_p1[k];
            end
        end
    end

    assign busy       = busy_r;
    assign col_out    = col_p2;
    assign hblank_out = tim_p2[0];
    assign vblank_out = tim_p2[1];
    assign hs_out     = tim_p2[2];
    assign vs_out     = tim_p2[3];

endmodule

// File: tb/tb_rgbi_palette_pipe.sv
module tb_rgbi_palette_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce_pix;
    logic [11:0] col_in;
    logic [3:0]  int_in;
    logic        hblank_in, vblank_in, hs_in, vs_in;
    logic        dn_wr;
    logic [7:0]  dn_addr;
    logic [7:0]  dn_data;
    logic        busy;
    logic [23:0] col_out;
    logic        hblank_out, vblank_out, hs_out, vs_out;
    logic [3:0]  tim_out;

    logic [19:0] col_in2;
    logic [2:0]  int_in2;
    logic        zero_b;
    logic [7:0]  dn_addr2;
    logic [5:0]  dn_data2;
    logic        busy2;
    logic [23:0] col_out2;
    logic        hb2, vb2, hs2, vs2;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [11:0] col;
        logic [3:0]  intens;
        logic [3:0]  tim;
        logic [23:0] ecol;
        logic [3:0]  etim;
    } vec_t;
    vec_t vec [8];

    assign tim_out = {vs_out, hs_out, vblank_out, hblank_out};

    always #5 clk = ~clk;

    rgbi_palette_pipe dut (
        .clk_video  (clk),
        .reset      (reset),
        .ce_pix     (ce_pix),
        .col_in     (col_in),
        .int_in     (int_in),
        .hblank_in  (hblank_in),
        .vblank_in  (vblank_in),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .dn_wr      (dn_wr),
        .dn_addr    (dn_addr),
        .dn_data    (dn_data),
        .busy       (busy),
        .col_out    (col_out),
        .hblank_out (hblank_out),
        .vblank_out (vblank_out),
        .hs_out     (hs_out),
        .vs_out     (vs_out)
    );

    rgbi_palette_pipe #(
        .CW(5), .IW(3), .OW(6), .NCH(4)
    ) dut2 (
        .clk_video  (clk),
        .reset      (reset),
        .ce_pix     (ce_pix),
        .col_in     (col_in2),
        .int_in     (int_in2),
        .hblank_in  (zero_b),
        .vblank_in  (zero_b),
        .hs_in      (zero_b),
        .vs_in      (zero_b),
        .dn_wr      (zero_b),
        .dn_addr    (dn_addr2),
        .dn_data    (dn_data2),
        .busy       (busy2),
        .col_out    (col_out2),
        .hblank_out (hb2),
        .vblank_out (vb2),
        .hs_out     (hs2),
        .vs_out     (vs2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_pix(input logic [11:0] c, input logic [3:0] i, input logic [3:0] t);
        col_in = c;
        int_in = i;
        {vs_in, hs_in, vblank_in, hblank_in} = t;
    endtask

    task automatic ce_pulse();
        ce_pix = 1'b0;
        tick();
        tick();
        tick();
        ce_pix = 1'b1;
        tick();
        ce_pix = 1'b0;
    endtask

    task automatic ce_pulse_wr(input logic [7:0] a, input logic [7:0] d);
        ce_pix = 1'b0;
        tick();
        tick();
        tick();
        ce_pix  = 1'b1;
        dn_wr   = 1'b1;
        dn_addr = a;
        dn_data = d;
        tick();
        ce_pix = 1'b0;
        dn_wr  = 1'b0;
    endtask

    // Reset, then run the default fill with ce every 4th cycle, trying two
    // downloads along the way which must be dropped.
    task automatic do_init(input string tag);
        int   n;
        logic col_bad;
        logic hs_seen;
        set_pix(12'hFFF, 4'hF, 4'b0100);
        ce_pix  = 1'b0;
        dn_wr   = 1'b0;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        check({tag, "_rst_busy"}, 32'(busy), 32'd1);
        check({tag, "_rst_col"}, 32'(col_out), 32'd0);
        check({tag, "_rst_tim"}, 32'(tim_out), 32'd0);
        n       = 0;
        col_bad = 1'b0;
        hs_seen = 1'b0;
        while (busy && n < 400) begin
            ce_pix  = (n % 4 == 3);
            dn_wr   = (n == 50) || (n == 100);
            dn_addr = (n == 50) ? 8'hFF : 8'h11;
            dn_data = (n == 50) ? 8'hFF : 8'hAA;
            if (col_out !== 24'h0) col_bad = 1'b1;
            if (hs_out === 1'b1) hs_seen = 1'b1;
            n++;
            tick();
        end
        ce_pix = 1'b0;
        dn_wr  = 1'b0;
        check({tag, "_busy_cycles"}, 32'(n), 32'd256);
        check({tag, "_col_zero_init"}, 32'(col_bad), 32'd0);
        check({tag, "_tim_in_init"}, 32'(hs_seen), 32'd1);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset    = 1'b0;
        ce_pix   = 1'b0;
        dn_wr    = 1'b0;
        dn_addr  = 8'h00;
        dn_data  = 8'h00;
        zero_b   = 1'b0;
        dn_addr2 = 8'h00;
        dn_data2 = 6'h00;
        col_in2  = {5'd1, 5'd16, 5'd0, 5'd31};
        int_in2  = 3'd7;
        set_pix(12'h000, 4'h0, 4'h0);

        vec[0] = '{12'h111, 4'h1, 4'b0000, 24'h010101, 4'b0000};
        vec[1] = '{12'hFFF, 4'hF, 4'b0000, 24'hE1E1E1, 4'b0000};
        vec[2] = '{12'hFFF, 4'h0, 4'b0000, 24'h000000, 4'b0000};
        vec[3] = '{12'h13A, 4'h5, 4'b0000, 24'h050F32, 4'b0000};
        vec[4] = '{12'hFFF, 4'hF, 4'b0001, 24'h000000, 4'b0001};
        vec[5] = '{12'hFFF, 4'hF, 4'b0010, 24'h000000, 4'b0010};
        vec[6] = '{12'h333, 4'hF, 4'b1000, 24'h2D2D2D, 4'b1000};
        vec[7] = '{12'h000, 4'hF, 4'b0100, 24'h000000, 4'b0100};

        tick();
        do_init("init1");
        check("dut2_busy_low", 32'(busy2), 32'd0);

        // Directed pixels, each expected exactly 3 ce pulses after entry
        for (int j = 0; j < 10; j++) begin
            if (j < 8) set_pix(vec[j].col, vec[j].intens, vec[j].tim);
            ce_pulse();
            if (j >= 2) begin
                check($sformatf("vec%0d_col", j - 2), 32'(col_out), 32'(vec[j-2].ecol));
                check($sformatf("vec%0d_tim", j - 2), 32'(tim_out), 32'(vec[j-2].etim));
            end
        end
        check("dut2_col", 32'(col_out2), 32'({6'd1, 6'd28, 6'd0, 6'd54}));
        check("dut2_tim", 32'({vs2, hs2, vb2, hb2}), 32'd0);

        // Freeze 10 cycles with changing inputs and a download
        ce_pix = 1'b0;
        for (int c = 0; c < 10; c++) begin
            set_pix(12'($urandom), 4'($urandom), 4'($urandom));
            dn_wr   = (c == 5);
            dn_addr = 8'hFF;
            dn_data = 8'hFF;
            tick();
        end
        dn_wr = 1'b0;
        check("freeze_col", 32'(col_out), 32'h0);
        check("freeze_tim", 32'(tim_out), 32'b0100);

        set_pix(12'hFFF, 4'hF, 4'b0000);
        ce_pulse();
        check("resume1_tim", 32'(tim_out), 32'b0100);
        set_pix(12'h13A, 4'h5, 4'b0000);
        ce_pulse();
        check("resume2_tim", 32'(tim_out), 32'b0100);
        ce_pulse();
        check("resume3_col", 32'(col_out), 32'hFFFFFF);
        check("resume3_tim", 32'(tim_out), 32'b0000);
        ce_pulse();
        check("resume4_col", 32'(col_out), 32'h050F32);

        // Write and read of the same entry in one cycle returns old data
        set_pix(12'hFFF, 4'hF, 4'b0000);
        ce_pulse();
        ce_pulse_wr(8'hFF, 8'h77);
        ce_pulse();
        check("rw_old_col", 32'(col_out), 32'hFFFFFF);
        ce_pulse();
        check("rw_new_col", 32'(col_out), 32'h777777);

        // Reset mid-run restores defaults
        do_init("init2");
        set_pix(12'hFFF, 4'hF, 4'b0000);
        ce_pulse();
        ce_pulse();
        ce_pulse();
        check("reinit_ff_col", 32'(col_out), 32'hE1E1E1);
        set_pix(12'h111, 4'h1, 4'b0000);
        ce_pulse();
        ce_pulse();
        ce_pulse();
        check("reinit_11_col", 32'(col_out), 32'h010101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rgbi_palette_pipe.md
Name: rgbi_palette_pipe

Overview:
- Parametrised successor to the fixed 4-bit RGBI colour-lookup stage used in the Williams arcade tops.
- Converts NCH colour channels plus a shared intensity nibble into OUT_W-bit video through a shared, download-writable lookup table.
- Delays blanking and sync so they stay aligned with the colour data, and gates the pipeline with the pixel clock-enable.
- Sits between the game core's video outputs and arcade_video, in the clk_video domain.

Parameters:
- CW, 4: colour bits per channel.
- IW, 4: intensity bits.
- OW, 8: output bits per channel.
- NCH, 3: number of colour channels (3 = R,G,B).
- BLANK_BLACK, 1: 1 = force the output to 0 while hblank or vblank is high.

Ports:
- clk_video  in  1  video clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- ce_pix  in  1  pixel enable; the pipeline advances only when it is 1.
- col_in  in  NCH*CW  packed channels; channel 0 in the LSBs.
- int_in  in  IW  intensity.
- hblank_in, vblank_in, hs_in, vs_in  in  1 each  timing inputs.
- dn_wr  in  1  table write strobe, one cycle.
- dn_addr  in  CW+IW  table index {colour, intensity}.
- dn_data  in  OW  table entry.
- busy  out  1  high while the table is being initialised.
- col_out  out  NCH*OW  packed output.
- hblank_out, vblank_out, hs_out, vs_out  out  1 each  delayed timing.

Behaviour:
Storage and address
- One table of 2^(CW+IW) entries of OW bits, physically replicated NCH times so each channel has its own read port.
- Every write goes to all replicas.
- Channel k reads at address {col_in[k], int_in}.

FSM, states INIT and RUN
- reset=1 puts the FSM in INIT, clears the fill counter, drives busy=1, and drives all outputs to 0.
- Reset asserted mid-fill or mid-run restarts INIT from index 0.
- INIT writes one entry per clk_video cycle, independent of ce_pix, over indices 0 to 2^(CW+IW)-1.
- Default entry for index {c,i}:
  - Form P = c*i, width CW+IW.
  - If OW <= CW+IW, the entry is P[CW+IW-1 -: OW].
  - Otherwise the entry is P zero-extended to OW bits.
- On the cycle the last index is written, the FSM moves to RUN, and busy drops on the next cycle.
- dn_wr is ignored in INIT. No queuing: the write is dropped.

Writes in RUN
- dn_wr writes dn_data at dn_addr.
- The write is visible to a read issued one or more cycles later.
- A read of the same address in the same cycle returns the old data.

Pipeline, 3 ce_pix-qualified stages
- S1 registers col_in, int_in, and the timing inputs.
- S2 is the synchronous table read; timing is carried alongside.
- S3 is the output register.
- Output rules at S3:
  - If the registered intensity is 0, col_out = 0 for every channel, whatever the table holds.
  - Else if BLANK_BLACK=1 and the registered hblank or vblank is 1, col_out = 0.
  - Else col_out holds the table data.
- Latency is exactly 3 ce_pix pulses for both colour and timing. Outputs hold their value between pulses.
- While busy=1, col_out=0, and the timing outputs still propagate with the same latency.
- ce_pix held at 0 freezes every stage, including on a dn_wr cycle. The write still completes.

Decomposition:
- Package rgbi_pkg holds:
  - localparam functions for the table depth, 2^(CW+IW);
  - the default-entry function, f(c,i,CW,IW,OW);
  - a typedef for the FSM state enum {INIT, RUN}.
- One natural sub-module, rgbi_lut_ram: a single-write, single-read synchronous RAM of OW by 2^(CW+IW), instantiated NCH times.
- The FSM, fill counter, and pipeline live in the top block.

Test Plan:
- Release reset with defaults, ce_pix pulsing every 4th cycle -> busy=1 for exactly 256 cycles, then 0. Afterwards col_in={4'hF,4'hF,4'hF} with int_in=4'hF gives col_out=24'hE1E1E1 (P=225) exactly 3 ce pulses later.
- After init, int_in=0 with col_in=all F -> col_out=0. Then hblank_in=1 with int_in=F -> col_out=0, and hblank_out rises on the same ce pulse as the data.
- dn_wr at addr 8'hFF with data 8'hFF -> the next pixel {F,F,F,F} gives col_out=24'hFFFFFF. A dn_wr during INIT at the same address is dropped, and the entry keeps its default value 8'hE1.
- ce_pix held at 0 for 10 cycles while inputs change -> col_out and the timing outputs are unchanged. On resume, the values enter in order with 3-pulse latency.
- Assert reset for 1 cycle mid-RUN after a download -> busy re-asserts, the table returns to defaults (index {F,F} = 8'hE1), and outputs are 0 during INIT.
- Parameter sweep CW=5, IW=3, OW=6: index {31,7} -> P=217 (8 bits), entry = P[7:2] = 54. Check channels NCH=4 in their packed order.
